// File: rtl/down_counter_pkg.sv
// down_counter_pkg: shared definitions for the loadable down counter.
//   DOWN_COUNTER_WIDTH_DEFAULT : default counter / load-value width.
//   state_t                    : FSM state encoding (IDLE, RUN, DONE).
package down_counter_pkg;

  localparam int DOWN_COUNTER_WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // stopped, not armed
    RUN  = 2'd1,  // decrementing on count strobes
    DONE = 2'd2   // expired, holding zero
  } state_t;

endpackage

// File: rtl/down_counter_if.sv
// down_counter_if: control and status bundle of the down counter.
//   load    : load din into the counter (and reload register)
//   count   : decrement strobe, one step per cycle while high
//   din     : load value
//   a_count : current count (registered)
//   b_out   : borrow flag, high when a_count == 0 (combinational)
//   tc      : one-cycle terminal-count pulse (registered)
//   busy    : high while the FSM is in RUN (registered)
// Handshake: there is no valid/ready pair. load/count are level strobes
// sampled on every rising clk edge; the status outputs are valid every
// cycle and reflect the result of the previous edge.
// master drives the controls, slave (the counter) drives the status.
interface down_counter_if
  import down_counter_pkg::*;
#(
  parameter int WIDTH = DOWN_COUNTER_WIDTH_DEFAULT
);

  logic             load;
  logic             count;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] a_count;
  logic             b_out;
  logic             tc;
  logic             busy;

  modport master (
    output load, count, din,
    input  a_count, b_out, tc, busy
  );

  modport slave (
    input  load, count, din,
    output a_count, b_out, tc, busy
  );

endinterface

// File: rtl/down_counter.sv
// down_counter: loadable down counter / timer that stops at zero.
// Optional feature macro: DOWN_COUNTER_AUTORELOAD_EN -- on expiry the count
// reloads from the last loaded value and stays in RUN (periodic divider).
// Ports:
//   clk     : clock, rising edge
//   clear   : synchronous active-high reset
//   bus     : down_counter_if.slave (load/count/din in; a_count/b_out/tc/busy out)
//   state_o : current FSM state, for debug/observation
// Priority each cycle: clear > load > count.
module down_counter
  import down_counter_pkg::*;
#(
  parameter int WIDTH = DOWN_COUNTER_WIDTH_DEFAULT
) (
  input  logic           clk,
  input  logic           clear,
  down_counter_if.slave  bus,
  output state_t         state_o
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             busy_q, busy_d;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tc_d    = 1'b0;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
    reload_d = reload_q;
`endif
    if (bus.load) begin
      // Load wins over count: no decrement and no tc in this cycle.
      count_d = bus.din;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
      reload_d = bus.din;
`endif
      state_d = (bus.din != '0) ? RUN : IDLE;
    end else if (state_q == RUN && bus.count && count_q != '0) begin
      // The non-zero guard keeps the counter from ever wrapping to all-ones.
      if (count_q == ONE) begin
        tc_d = 1'b1;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
        count_d = reload_q;
`else
        count_d = '0;
        state_d = DONE;
`endif
      end else begin
        count_d = count_q - ONE;
      end
    end
    // busy is registered alongside the state so both move on the same edge.
    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q  <= IDLE;
      count_q  <= '0;
      tc_q     <= 1'b0;
      busy_q   <= 1'b0;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      tc_q     <= tc_d;
      busy_q   <= busy_d;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

  assign bus.a_count = count_q;
  assign bus.b_out   = (count_q == '0);
  assign bus.tc      = tc_q;
  assign bus.busy    = busy_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_down_counter.sv
// tb_down_counter: directed bench for down_counter with an expected-value queue.
module tb_down_counter;
  import down_counter_pkg::*;

  localparam int WIDTH = 4;
  localparam int W     = WIDTH + 3;  // {a_count, b_out, tc, busy}

  // ---------------- clock / reset ----------------
  logic clk;
  logic clear;
  state_t state_dbg;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  down_counter_if #(.WIDTH(WIDTH)) bus ();

  down_counter #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .clear   (clear),
    .bus     (bus),
    .state_o (state_dbg)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int           id_q[$];
  int           checks = 0;
  int           errors = 0;
  int           step_id = 0;

  // Drive one cycle of inputs at the falling edge and queue the outputs
  // expected after the following rising edge.
  task automatic step(input logic clr, input logic ld, input logic cnt,
                      input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] ea,
                      input logic etc, input logic ebusy);
    @(negedge clk);
    clear     = clr;
    bus.load  = ld;
    bus.count = cnt;
    bus.din   = d;
    exp_q.push_back({ea, (ea == '0), etc, ebusy});
    id_q.push_back(step_id);
    step_id++;
  endtask

  // Monitor: outputs are valid every cycle, sampled 1 time unit after the edge.
  always @(posedge clk) begin
    logic [W-1:0] e;
    int           id;
    #1;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      id = id_q.pop_front();
      checks++;
      if (bus.a_count !== e[W-1:3]) begin
        errors++;
        $display("FAIL a_count step %0d: got %0d expected %0d", id, bus.a_count, e[W-1:3]);
      end
      checks++;
      if (bus.b_out !== e[2]) begin
        errors++;
        $display("FAIL b_out step %0d: got %b expected %b", id, bus.b_out, e[2]);
      end
      checks++;
      if (bus.tc !== e[1]) begin
        errors++;
        $display("FAIL tc step %0d: got %b expected %b", id, bus.tc, e[1]);
      end
      checks++;
      if (bus.busy !== e[0]) begin
        errors++;
        $display("FAIL busy step %0d: got %b expected %b", id, bus.busy, e[0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    clear     = 1'b1;
    bus.load  = 1'b0;
    bus.count = 1'b0;
    bus.din   = '0;

    // Reset held two cycles.
    step(1, 0, 0, 4'd0, 4'd0, 0, 0);
    step(1, 0, 0, 4'd0, 4'd0, 0, 0);

    // Load 3 then count down to expiry.
    step(0, 1, 0, 4'd3, 4'd3, 0, 1);
    step(0, 0, 0, 4'd0, 4'd3, 0, 1);  // hold in RUN without count
`ifdef DOWN_COUNTER_AUTORELOAD_EN
    step(0, 0, 1, 4'd0, 4'd2, 0, 1);
    step(0, 0, 1, 4'd0, 4'd1, 0, 1);
    step(0, 0, 1, 4'd0, 4'd3, 1, 1);  // reload from 3
    step(0, 0, 1, 4'd0, 4'd2, 0, 1);
`else
    step(0, 0, 1, 4'd0, 4'd2, 0, 1);
    step(0, 0, 1, 4'd0, 4'd1, 0, 1);
    step(0, 0, 1, 4'd0, 4'd0, 1, 0);  // expiry: tc pulse, DONE
    step(0, 0, 1, 4'd0, 4'd0, 0, 0);  // DONE ignores count
    step(0, 0, 1, 4'd0, 4'd0, 0, 0);
`endif

    // Load 0 -> IDLE, count ignored.
    step(0, 1, 0, 4'd0, 4'd0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 4'd0, 4'd0, 0, 0);

    // Load 5 with count on the same cycle: load only.
    step(0, 1, 1, 4'd5, 4'd5, 0, 1);
    step(0, 0, 1, 4'd0, 4'd4, 0, 1);
    step(0, 0, 1, 4'd0, 4'd3, 0, 1);
    step(1, 0, 1, 4'd0, 4'd0, 0, 0);  // clear aborts RUN
    step(0, 0, 1, 4'd0, 4'd0, 0, 0);  // IDLE ignores count

    // Clear on the expiring cycle cancels the tc pulse.
    step(0, 1, 0, 4'd1, 4'd1, 0, 1);
    step(1, 0, 1, 4'd0, 4'd0, 0, 0);

    // Reload mid-run, max value boundary.
    step(0, 1, 0, 4'd15, 4'd15, 0, 1);
    step(0, 0, 1, 4'd0, 4'd14, 0, 1);
    step(0, 1, 1, 4'd6, 4'd6, 0, 1);
    step(0, 0, 1, 4'd0, 4'd5, 0, 1);

`ifdef DOWN_COUNTER_AUTORELOAD_EN
    // Period-4 divider: 12 strobes, 3 tc pulses.
    step(0, 1, 0, 4'd4, 4'd4, 0, 1);
    for (int p = 0; p < 3; p++) begin
      step(0, 0, 1, 4'd0, 4'd3, 0, 1);
      step(0, 0, 1, 4'd0, 4'd2, 0, 1);
      step(0, 0, 1, 4'd0, 4'd1, 0, 1);
      step(0, 0, 1, 4'd0, 4'd4, 1, 1);
    end
    // Reload value 1: tc every strobe, count stays 1.
    step(0, 1, 0, 4'd1, 4'd1, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 4'd0, 4'd1, 1, 1);
    step(0, 0, 0, 4'd0, 4'd1, 0, 1);
`else
    // Load 1 expires on the first strobe.
    step(0, 1, 0, 4'd1, 4'd1, 0, 1);
    step(0, 0, 1, 4'd0, 4'd0, 1, 0);
    step(0, 0, 1, 4'd0, 4'd0, 0, 0);
`endif

    // Leaving DONE/IDLE via load.
    step(0, 1, 0, 4'd2, 4'd2, 0, 1);
    step(0, 0, 0, 4'd0, 4'd2, 0, 1);

    // Drain: the monitor must have consumed every expected entry.
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
